spi_flash_ctrl: RTL and testbench



---
 rtl/spi_flash_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_spi_flash_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_ctrl.sv
// SPI flash command sequencer: expands read / page-program / sector-erase requests
// into WREN, main command and RDSR polling operations for the bit-level driver.
// Optional build macro: SPI_FLASH_CTRL_FAST_READ_EN (0x0B fast read with one dummy byte).
module spi_flash_ctrl #(
  parameter logic [15:0] P_POLL_MAX = 16'd50000,
  parameter logic [15:0] P_POLL_GAP = 16'd64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_user_cmd,
  input  logic [23:0] i_user_addr,
  input  logic [8:0]  i_user_len,
  input  logic        i_user_valid,
  output logic        o_user_ready,
  input  logic [7:0]  i_user_wdata,
  input  logic        i_user_wvalid,
  output logic        o_user_wready,
  output logic [7:0]  o_user_rdata,
  output logic        o_user_rvalid,
  output logic        o_user_done,
  output logic        o_user_err,
  output logic [31:0] o_drv_op_data,
  output logic [1:0]  o_drv_op_type,
  output logic [15:0] o_drv_op_data_len,
  output logic [15:0] o_drv_op_clk_len,
  output logic        o_drv_op_valid,
  input  logic        i_drv_op_ready,
  input  logic        i_drv_write_req,
  output logic [7:0]  o_drv_write_data,
  input  logic [7:0]  i_drv_read_data,
  input  logic        i_drv_read_valid,
  output logic [3:0]  o_dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the sender keeps valid and its payload stable until then. The driver drops
  // i_drv_op_ready the cycle after accepting and raises it again when the operation ends.
  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_WAIT, S_MAIN, S_MAIN_WAIT, S_POLL, S_POLL_WAIT, S_GAP, S_DONE
  } state_t;

  localparam logic [1:0] CMD_READ = 2'd0, CMD_PROG = 2'd1, CMD_ERASE = 2'd2;
  localparam logic [1:0] T_CMD = 2'd0, T_READ = 2'd1, T_WRITE = 2'd2;
`ifdef SPI_FLASH_CTRL_FAST_READ_EN
  localparam logic [7:0]  OP_READ = 8'h0B;
  localparam logic [15:0] RD_HDR  = 16'd40;
`else
  localparam logic [7:0]  OP_READ = 8'h03;
  localparam logic [15:0] RD_HDR  = 16'd32;
`endif

  state_t      state, state_nxt;
  logic [1:0]  cmd_q;
  logic [23:0] addr_q;
  logic [8:0]  len_q, rd_cnt;
  logic        err_q, underrun_q, stage_full, busy_q;
  logic [7:0]  stage_q;
  logic [15:0] poll_cnt, gap_cnt, data_clks;
  logic [9:0]  page_end;
  logic        reject, busy_now, timeout, rd_strobe, rd_fwd, fill, first_ok;

  assign page_end  = {2'b00, i_user_addr[7:0]} + {1'b0, i_user_len};
  assign reject    = (i_user_cmd == 2'd3)
                  || ((i_user_cmd != CMD_ERASE) && ((i_user_len == 9'd0) || (i_user_len > 9'd256)))
                  || ((i_user_cmd == CMD_PROG) && (page_end > 10'd256));
  assign data_clks = {4'b0000, len_q, 3'b000};
  assign busy_now  = i_drv_read_valid ? i_drv_read_data[0] : busy_q;
  assign timeout   = (poll_cnt >= P_POLL_MAX);
  assign rd_strobe = (state == S_MAIN_WAIT) && (cmd_q == CMD_READ) && i_drv_read_valid;
  assign rd_fwd    = rd_strobe && first_ok;
  assign fill      = i_user_wvalid && !stage_full;

`ifdef SPI_FLASH_CTRL_FAST_READ_EN
  logic dummy_seen;
  assign first_ok = dummy_seen;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            dummy_seen <= 1'b0;
    else if (state == S_DONE) dummy_seen <= 1'b0;
    else if (rd_strobe)       dummy_seen <= 1'b1;
  end
`else
  assign first_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (i_user_valid)
                     state_nxt = reject ? S_DONE : ((i_user_cmd == CMD_READ) ? S_MAIN : S_WREN);
      S_WREN:      if (i_drv_op_ready) state_nxt = S_WREN_WAIT;
      S_WREN_WAIT: if (i_drv_op_ready) state_nxt = S_MAIN;
      S_MAIN:      if (i_drv_op_ready) state_nxt = S_MAIN_WAIT;
      S_MAIN_WAIT: if (i_drv_op_ready) state_nxt = (cmd_q == CMD_READ) ? S_DONE : S_POLL;
      S_POLL:      if (i_drv_op_ready) state_nxt = S_POLL_WAIT;
      S_POLL_WAIT: if (i_drv_op_ready) state_nxt = (!busy_now || timeout) ? S_DONE : S_GAP;
      S_GAP:       if (gap_cnt + 16'd1 >= P_POLL_GAP) state_nxt = S_POLL;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Op fields are a pure function of state and latched request, so they hold while valid is up.
  always_comb begin
    o_drv_op_valid    = 1'b0;
    o_drv_op_data     = 32'h0;
    o_drv_op_type     = T_CMD;
    o_drv_op_data_len = 16'd0;
    o_drv_op_clk_len  = 16'd0;
    case (state)
      S_WREN: begin
        o_drv_op_valid    = 1'b1;
        o_drv_op_data     = {8'h06, 24'h0};
        o_drv_op_data_len = 16'd8;
        o_drv_op_clk_len  = 16'd8;
      end
      S_MAIN: begin
        o_drv_op_valid    = 1'b1;
        o_drv_op_data_len = 16'd32;
        case (cmd_q)
          CMD_READ: begin
            o_drv_op_data    = {OP_READ, addr_q};
            o_drv_op_type    = T_READ;
            o_drv_op_clk_len = RD_HDR + data_clks;
          end
          CMD_PROG: begin
            o_drv_op_data    = {8'h02, addr_q};
            o_drv_op_type    = T_WRITE;
            o_drv_op_clk_len = 16'd32 + data_clks;
          end
          default: begin
            o_drv_op_data    = {8'h20, addr_q};
            o_drv_op_clk_len = 16'd32;
          end
        endcase
      end
      S_POLL: begin
        o_drv_op_valid    = 1'b1;
        o_drv_op_data     = {8'h05, 24'h0};
        o_drv_op_type     = T_READ;
        o_drv_op_data_len = 16'd8;
        o_drv_op_clk_len  = 16'd16;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cmd_q         <= 2'd0;
      addr_q        <= 24'h0;
      len_q         <= 9'd0;
      err_q         <= 1'b0;
      underrun_q    <= 1'b0;
      busy_q        <= 1'b0;
      poll_cnt      <= 16'd0;
      gap_cnt       <= 16'd0;
      rd_cnt        <= 9'd0;
      stage_full    <= 1'b0;
      stage_q       <= 8'h0;
      o_user_rvalid <= 1'b0;
      o_user_rdata  <= 8'h0;
    end else begin
      state         <= state_nxt;
      o_user_rvalid <= rd_fwd;
      gap_cnt       <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if ((state == S_IDLE) && i_user_valid) begin
        cmd_q  <= i_user_cmd;
        addr_q <= i_user_addr;
        len_q  <= i_user_len;
        err_q  <= reject;
      end
      if ((state == S_POLL) && i_drv_op_ready) poll_cnt <= poll_cnt + 16'd1;
      if ((state == S_POLL_WAIT) && i_drv_read_valid) busy_q <= i_drv_read_data[0];
      if ((state == S_POLL_WAIT) && i_drv_op_ready && busy_now && timeout) err_q <= 1'b1;
      if (rd_fwd) begin
        o_user_rdata <= i_drv_read_data;
        rd_cnt       <= rd_cnt + 9'd1;
      end
      // A fresh byte wins over a concurrent drain, so the register stays full.
      if (fill) begin
        stage_q    <= i_user_wdata;
        stage_full <= 1'b1;
      end else if (i_drv_write_req) begin
        stage_full <= 1'b0;
      end
      if (i_drv_write_req && !stage_full) underrun_q <= 1'b1;
      if (state == S_DONE) begin
        err_q      <= 1'b0;
        underrun_q <= 1'b0;
        busy_q     <= 1'b0;
        poll_cnt   <= 16'd0;
        rd_cnt     <= 9'd0;
      end
    end
  end

  assign o_user_ready     = (state == S_IDLE);
  assign o_user_wready    = !stage_full;
  assign o_drv_write_data = stage_q;
  assign o_user_done      = (state == S_DONE);
  assign o_user_err       = (state == S_DONE)
                         && (err_q || underrun_q || ((cmd_q == CMD_READ) && (rd_cnt != len_q)));
  assign o_dbg_state      = state;
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed bench for spi_flash_ctrl with a behavioural driver model and read-byte scoreboard.
module tb_spi_flash_ctrl;
  localparam logic [15:0] POLL_MAX = 16'd4;
  localparam logic [15:0] POLL_GAP = 16'd4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_user_cmd = 2'd0;
  logic [23:0] i_user_addr = 24'h0;
  logic [8:0]  i_user_len = 9'd0;
  logic        i_user_valid = 1'b0;
  logic        o_user_ready;
  logic [7:0]  i_user_wdata;
  logic        i_user_wvalid;
  logic        o_user_wready;
  logic [7:0]  o_user_rdata;
  logic        o_user_rvalid;
  logic        o_user_done;
  logic        o_user_err;
  logic [31:0] o_drv_op_data;
  logic [1:0]  o_drv_op_type;
  logic [15:0] o_drv_op_data_len;
  logic [15:0] o_drv_op_clk_len;
  logic        o_drv_op_valid;
  logic        i_drv_op_ready = 1'b1;
  logic        i_drv_write_req = 1'b0;
  logic [7:0]  o_drv_write_data;
  logic [7:0]  i_drv_read_data = 8'h0;
  logic        i_drv_read_valid = 1'b0;
  logic [3:0]  o_dbg_state;

  logic        tb_wvalid = 1'b0;
  logic [7:0]  tb_wdata = 8'h0;
  logic        drv_wvalid = 1'b0;
  logic [7:0]  drv_wdata = 8'h0;
  assign i_user_wvalid = tb_wvalid | drv_wvalid;
  assign i_user_wdata  = drv_wvalid ? drv_wdata : tb_wdata;

  // clock / reset
  always #5 i_clk = ~i_clk;

  spi_flash_ctrl #(.P_POLL_MAX(POLL_MAX), .P_POLL_GAP(POLL_GAP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_user_cmd(i_user_cmd), .i_user_addr(i_user_addr), .i_user_len(i_user_len),
    .i_user_valid(i_user_valid), .o_user_ready(o_user_ready),
    .i_user_wdata(i_user_wdata), .i_user_wvalid(i_user_wvalid), .o_user_wready(o_user_wready),
    .o_user_rdata(o_user_rdata), .o_user_rvalid(o_user_rvalid),
    .o_user_done(o_user_done), .o_user_err(o_user_err),
    .o_drv_op_data(o_drv_op_data), .o_drv_op_type(o_drv_op_type),
    .o_drv_op_data_len(o_drv_op_data_len), .o_drv_op_clk_len(o_drv_op_clk_len),
    .o_drv_op_valid(o_drv_op_valid), .i_drv_op_ready(i_drv_op_ready),
    .i_drv_write_req(i_drv_write_req), .o_drv_write_data(o_drv_write_data),
    .i_drv_read_data(i_drv_read_data), .i_drv_read_valid(i_drv_read_valid),
    .o_dbg_state(o_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_rv  = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  stat_q[$];
  logic [7:0]  wr_log[$];
  logic [31:0] op_data_log[$];
  logic [1:0]  op_type_log[$];
  logic [15:0] op_dlen_log[$];
  logic [15:0] op_clen_log[$];
  bit          auto_fill = 1'b1;
  int          drv_nbytes;
  logic [1:0]  drv_type;
  bit          drv_poll;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver model: logs each accepted op, then plays its data phase.
  always begin
    @(posedge i_clk);
    if (o_drv_op_valid && i_drv_op_ready) begin
      op_data_log.push_back(o_drv_op_data);
      op_type_log.push_back(o_drv_op_type);
      op_dlen_log.push_back(o_drv_op_data_len);
      op_clen_log.push_back(o_drv_op_clk_len);
      drv_nbytes = int'((o_drv_op_clk_len - o_drv_op_data_len) >> 3);
      drv_type   = o_drv_op_type;
      drv_poll   = (o_drv_op_data[31:24] == 8'h05);
      #1 i_drv_op_ready = 1'b0;
      @(posedge i_clk); #1;
      for (int k = 0; k < drv_nbytes; k++) begin
        if (drv_type == 2'd1) begin
          if (drv_poll) i_drv_read_data = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h01;
          else          i_drv_read_data = 8'(8'hA0 + k);
          i_drv_read_valid = 1'b1;
          @(posedge i_clk); #1 i_drv_read_valid = 1'b0;
        end else if (drv_type == 2'd2) begin
          if (auto_fill && o_user_wready) begin
            drv_wdata  = 8'(8'h22 + k);
            drv_wvalid = 1'b1;
            @(posedge i_clk); #1 drv_wvalid = 1'b0;
          end
          wr_log.push_back(o_drv_write_data);
          i_drv_write_req = 1'b1;
          @(posedge i_clk); #1 i_drv_write_req = 1'b0;
        end
        @(posedge i_clk); #1;
      end
      i_drv_op_ready = 1'b1;
    end
  end

  // scoreboard for forwarded read bytes
  always @(negedge i_clk) begin
    if (o_user_rvalid) begin
      n_rv++;
      if (exp_q.size() == 0) check("rdata_unexpected", 32'(o_user_rvalid), 32'd0);
      else                   check("rdata", 32'(o_user_rdata), 32'(exp_q.pop_front()));
    end
  end

  task automatic send_req(input logic [1:0] cmd, input logic [23:0] addr, input logic [8:0] len);
    @(negedge i_clk);
    i_user_cmd   = cmd;
    i_user_addr  = addr;
    i_user_len   = len;
    i_user_valid = 1'b1;
    @(posedge i_clk); #1 i_user_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output logic err);
    bit got;
    got = 1'b0;
    err = 1'bx;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge i_clk);
      if (o_user_done) begin
        got = 1'b1;
        err = o_user_err;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic check_op(input string tag, input int idx, input logic [31:0] data,
                          input logic [1:0] typ, input logic [15:0] dlen, input logic [15:0] clen);
    check({tag, "_data"}, op_data_log[idx], data);
    check({tag, "_type"}, 32'(op_type_log[idx]), 32'(typ));
    check({tag, "_dlen"}, 32'(op_dlen_log[idx]), 32'(dlen));
    check({tag, "_clen"}, 32'(op_clen_log[idx]), 32'(clen));
  endtask

  initial begin
    logic err;
    int   base, rv0, polls;
    bit   hit;

    // reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_ready", 32'(o_user_ready), 32'd1);
    check("rst_wready", 32'(o_user_wready), 32'd1);
    check("rst_op_valid", 32'(o_drv_op_valid), 32'd0);
    check("rst_op_data", o_drv_op_data, 32'h0);
    check("rst_clk_len", 32'(o_drv_op_clk_len), 32'd0);
    check("rst_done", 32'(o_user_done), 32'd0);
    check("rst_err", 32'(o_user_err), 32'd0);
    check("rst_rvalid", 32'(o_user_rvalid), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    i_rst_n = 1'b1;

    // read 4 bytes at 0x001000
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA0 + i));
    rv0 = n_rv;
    send_req(2'd0, 24'h001000, 9'd4);
    @(negedge i_clk);
    check("rd_lat_valid", 32'(o_drv_op_valid), 32'd1);
    check("rd_op_data", o_drv_op_data, 32'h03001000);
    check("rd_op_type", 32'(o_drv_op_type), 32'd1);
    check("rd_op_dlen", 32'(o_drv_op_data_len), 32'd32);
    check("rd_op_clen", 32'(o_drv_op_clk_len), 32'd64);
    wait_done("rd", err);
    check("rd_err", 32'(err), 32'd0);
    check("rd_count", 32'(n_rv - rv0), 32'd4);
    check("rd_exp_left", 32'(exp_q.size()), 32'd0);

    // program 2 bytes at 0x0000FE, staging pre-filled with 0x11
    @(negedge i_clk);
    tb_wdata  = 8'h11;
    tb_wvalid = 1'b1;
    @(posedge i_clk); #1 tb_wvalid = 1'b0;
    @(negedge i_clk);
    check("pre_wready", 32'(o_user_wready), 32'd0);
    check("pre_wdata", 32'(o_drv_write_data), 32'h11);
    stat_q = '{8'h01, 8'h01, 8'h00};
    wr_log.delete();
    base = op_data_log.size();
    send_req(2'd1, 24'h0000FE, 9'd2);
    wait_done("pp", err);
    check("pp_err", 32'(err), 32'd0);
    check("pp_nops", 32'(op_data_log.size() - base), 32'd5);
    check_op("pp_wren", base, 32'h06000000, 2'd0, 16'd8, 16'd8);
    check_op("pp_main", base + 1, 32'h020000FE, 2'd2, 16'd32, 16'd48);
    check_op("pp_poll1", base + 2, 32'h05000000, 2'd1, 16'd8, 16'd16);
    check_op("pp_poll3", base + 4, 32'h05000000, 2'd1, 16'd8, 16'd16);
    check("pp_wr_n", 32'(wr_log.size()), 32'd2);
    check("pp_wr0", 32'(wr_log[0]), 32'h11);
    check("pp_wr1", 32'(wr_log[1]), 32'h23);

    // rejects: page crossing, reserved cmd, read len 0, read len 257
    base = op_data_log.size();
    send_req(2'd1, 24'h0000FF, 9'd3);
    wait_done("rej_page", err);
    check("rej_page_err", 32'(err), 32'd1);
    send_req(2'd3, 24'h000000, 9'd1);
    wait_done("rej_cmd3", err);
    check("rej_cmd3_err", 32'(err), 32'd1);
    send_req(2'd0, 24'h000000, 9'd0);
    wait_done("rej_len0", err);
    check("rej_len0_err", 32'(err), 32'd1);
    send_req(2'd0, 24'h000000, 9'd257);
    wait_done("rej_len257", err);
    check("rej_len257_err", 32'(err), 32'd1);
    check("rej_no_ops", 32'(op_data_log.size() - base), 32'd0);

    // erase with status stuck busy: timeout after POLL_MAX polls
    stat_q.delete();
    base = op_data_log.size();
    send_req(2'd2, 24'h012345, 9'd0);
    wait_done("er_stuck", err);
    check("er_stuck_err", 32'(err), 32'd1);
    check("er_stuck_nops", 32'(op_data_log.size() - base), 32'd6);
    check_op("er_main", base + 1, 32'h20012345, 2'd0, 16'd32, 16'd32);
    polls = 0;
    for (int i = base; i < op_data_log.size(); i++)
      if (op_data_log[i] == 32'h05000000) polls++;
    check("er_stuck_polls", 32'(polls), 32'd4);

    // program with empty staging register: underrun
    auto_fill = 1'b0;
    stat_q = '{8'h00};
    base = op_data_log.size();
    send_req(2'd1, 24'h000010, 9'd1);
    wait_done("underrun", err);
    check("underrun_err", 32'(err), 32'd1);
    check("underrun_nops", 32'(op_data_log.size() - base), 32'd3);
    auto_fill = 1'b1;

    // clean erase afterwards: flags must have cleared
    stat_q = '{8'h00};
    base = op_data_log.size();
    send_req(2'd2, 24'h020000, 9'd0);
    wait_done("er_ok", err);
    check("er_ok_err", 32'(err), 32'd0);
    check("er_ok_nops", 32'(op_data_log.size() - base), 32'd3);

    // reset during MAIN_WAIT
    send_req(2'd0, 24'h000200, 9'd4);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge i_clk);
      if (o_dbg_state == 4'd4) hit = 1'b1;
    end
    check("mrst_reached", 32'(hit), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("mrst_ready", 32'(o_user_ready), 32'd1);
    check("mrst_wready", 32'(o_user_wready), 32'd1);
    check("mrst_op_valid", 32'(o_drv_op_valid), 32'd0);
    check("mrst_op_data", o_drv_op_data, 32'h0);
    check("mrst_op_type", 32'(o_drv_op_type), 32'd0);
    check("mrst_clk_len", 32'(o_drv_op_clk_len), 32'd0);
    check("mrst_done", 32'(o_user_done), 32'd0);
    check("mrst_err", 32'(o_user_err), 32'd0);
    check("mrst_rvalid", 32'(o_user_rvalid), 32'd0);
    check("mrst_wdata", 32'(o_drv_write_data), 32'd0);
    check("mrst_state", 32'(o_dbg_state), 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge i_clk);
      if (i_drv_op_ready) hit = 1'b1;
    end
    check("mrst_drv_idle", 32'(hit), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // new request after release: full 256-byte read, maximum clk_len
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(8'hA0 + i));
    rv0 = n_rv;
    send_req(2'd0, 24'h000000, 9'd256);
    @(negedge i_clk);
    check("rd256_valid", 32'(o_drv_op_valid), 32'd1);
    check("rd256_data", o_drv_op_data, 32'h03000000);
    check("rd256_clen", 32'(o_drv_op_clk_len), 32'd2080);
    wait_done("rd256", err);
    check("rd256_err", 32'(err), 32'd0);
    check("rd256_count", 32'(n_rv - rv0), 32'd256);
    check("rd256_exp_left", 32'(exp_q.size()), 32'd0);

    repeat (3) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
